// File: rtl/fir_pkg.sv
// Shared types and constants for the time-multiplexed FIR MAC sequencer.
package fir_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    OUT
  } state_e;

  localparam int unsigned DefN    = 4;
  localparam int unsigned DefDw   = 8;
  localparam int unsigned DefCw   = 8;
  localparam int unsigned OutW    = 16;
  localparam int unsigned CoefRst = 1;

endpackage

// File: rtl/fir_mac_sequencer_if.sv
// Sample-in, result-out and coefficient-load signals of the FIR MAC sequencer.
interface fir_mac_sequencer_if
  import fir_pkg::*;
#(
  parameter int unsigned N  = DefN,
  parameter int unsigned DW = DefDw,
  parameter int unsigned CW = DefCw
) ();

  logic                 in_valid;
  logic [DW-1:0]        in_data;
  logic                 in_ready;
  logic                 out_valid;
  logic [OutW-1:0]      out_data;
  logic                 out_ready;
  logic                 coef_we;
  logic [$clog2(N)-1:0] coef_addr;
  logic [CW-1:0]        coef_data;
  logic                 busy;

  modport master (
    output in_valid, in_data, out_ready, coef_we, coef_addr, coef_data,
    input  in_ready, out_valid, out_data, busy
  );

  modport slave (
    input  in_valid, in_data, out_ready, coef_we, coef_addr, coef_data,
    output in_ready, out_valid, out_data, busy
  );

endinterface

// File: rtl/fir_coef_rf.sv
// N x CW coefficient register file: one write port, one combinational read port,
// every entry resets to CoefRst.
module fir_coef_rf
  import fir_pkg::*;
#(
  parameter int unsigned N  = DefN,
  parameter int unsigned CW = DefCw
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 we,
  input  logic [$clog2(N)-1:0] waddr,
  input  logic [CW-1:0]        wdata,
  input  logic [$clog2(N)-1:0] raddr,
  output logic [CW-1:0]        rdata
);

  logic [N-1:0][CW-1:0] coef_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N; i++) begin
        coef_q[i] <= CW'(CoefRst);
      end
    end else if (we) begin
      coef_q[waddr] <= wdata;
    end
  end

  assign rdata = coef_q[raddr];

endmodule

// File: rtl/fir_mac_sequencer.sv
// N-tap FIR using one multiply-accumulate unit stepped over N cycles per sample.
// Define FIR_SAT_EN to saturate the result to 16 bits instead of truncating it.
module fir_mac_sequencer
  import fir_pkg::*;
#(
  parameter int unsigned N  = DefN,
  parameter int unsigned DW = DefDw,
  parameter int unsigned CW = DefCw
) (
  input logic                clk,
  input logic                reset,
  fir_mac_sequencer_if.slave bus
);

  localparam int unsigned KW   = $clog2(N);
  localparam int unsigned AccW = DW + CW + KW;

  state_e               state_q, state_d;
  logic [KW-1:0]        k_q, k_d;
  logic [AccW-1:0]      acc_q, acc_d;
  logic [N-1:0][DW-1:0] x_q, x_d;
  logic [CW-1:0]        coef_rd;
  logic [AccW-1:0]      prod;
  logic                 coef_wr;

  // Writes are only taken while idle; an idle write lands before the next MAC reads it.
  assign coef_wr = bus.coef_we && (state_q == IDLE) && (32'(bus.coef_addr) < N);

  fir_coef_rf #(
    .N  (N),
    .CW (CW)
  ) u_coef_rf (
    .clk   (clk),
    .reset (reset),
    .we    (coef_wr),
    .waddr (bus.coef_addr),
    .wdata (bus.coef_data),
    .raddr (k_q),
    .rdata (coef_rd)
  );

  assign prod = AccW'(x_q[k_q]) * AccW'(coef_rd);

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    acc_d   = acc_q;
    x_d     = x_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          x_d     = {x_q[N-2:0], bus.in_data};
          acc_d   = '0;
          k_d     = '0;
          state_d = MAC;
        end
      end
      MAC: begin
        acc_d = acc_q + prod;
        k_d   = k_q + 1'b1;
        if (k_q == KW'(N - 1)) begin
          k_d     = '0;
          state_d = OUT;
        end
      end
      OUT: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      k_q     <= '0;
      acc_q   <= '0;
      x_q     <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      acc_q   <= acc_d;
      x_q     <= x_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == OUT);
  assign bus.busy      = (state_q != IDLE);

  // acc only changes in IDLE/MAC, so the result is stable for the whole OUT state.
`ifdef FIR_SAT_EN
  assign bus.out_data = (32'(acc_q) > 32'hFFFF) ? '1 : OutW'(acc_q);
`else
  assign bus.out_data = OutW'(acc_q);
`endif

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Self-checking bench for fir_mac_sequencer: directed scenarios plus randomized samples and
// coefficient loads, checked against a dot-product reference model.
module tb_fir_mac_sequencer;

  localparam int unsigned N = 4;

  logic clk;
  logic reset;

  fir_mac_sequencer_if #(.N(N), .DW(8), .CW(8)) bus ();

  fir_mac_sequencer #(.N(N), .DW(8), .CW(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Passive counters sampled on rising edges.
  int cyc     = 0;
  int n_acc   = 0;
  int n_xfer  = 0;
  int n_valid = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.in_valid && bus.in_ready)   n_acc  <= n_acc + 1;
    if (bus.out_valid && bus.out_ready) n_xfer <= n_xfer + 1;
    if (bus.out_valid)                  n_valid <= n_valid + 1;
  end

  // Reference model: delay line and coefficient set as plain integers.
  int xl [N];
  int cf [N];
  int accept_cyc;
  int valid_cyc;

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      xl[i] = 0;
      cf[i] = 1;
    end
  endfunction

  function automatic logic [31:0] model_out();
    longint s = 0;
    for (int i = 0; i < N; i++) s += longint'(xl[i]) * longint'(cf[i]);
`ifdef FIR_SAT_EN
    return (s > 65535) ? 32'hFFFF : 32'(s & 16'hFFFF);
`else
    return 32'(s & 16'hFFFF);
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    bus.in_valid = 1'b0;
    bus.coef_we  = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  // Called at a falling edge; returns at the falling edge after the accept edge.
  task automatic send(input logic [7:0] d);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    while (bus.in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("accept_timeout", 32'(n < 50), 1);
    @(posedge clk);
    @(negedge clk);
    accept_cyc   = cyc;
    bus.in_valid = 1'b0;
    for (int i = N - 1; i > 0; i--) xl[i] = xl[i-1];
    xl[0] = int'(d);
  endtask

  task automatic wait_result(input string tag);
    int n = 0;
    while (bus.out_valid !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_timeout"}, 32'(n < 50), 1);
    valid_cyc = cyc;
    check(tag, 32'(bus.out_data), model_out());
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus.busy !== 1'b0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", 32'(n < 50), 1);
  endtask

  task automatic write_coef(input int addr, input int data, input bit taken);
    bus.coef_we   = 1'b1;
    bus.coef_addr = 2'(addr);
    bus.coef_data = 8'(data);
    @(posedge clk);
    @(negedge clk);
    bus.coef_we = 1'b0;
    if (taken) cf[addr] = data;
  endtask

  initial begin
    int prev_acc;
    int xfer0;
    int acc0;
    int v0;
    logic [15:0] held;
    int samp [4];
    samp = '{10, 20, 30, 40};

    reset         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    bus.coef_we   = 1'b0;
    bus.coef_addr = '0;
    bus.coef_data = '0;
    model_reset();

    @(negedge clk);
    check("rst_in_ready", 32'(bus.in_ready), 1);
    check("rst_out_valid", 32'(bus.out_valid), 0);
    check("rst_out_data", 32'(bus.out_data), 0);
    check("rst_busy", 32'(bus.busy), 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Default coefficients of 1: running sums, fixed latency and accept spacing.
    prev_acc = 0;
    for (int i = 0; i < 4; i++) begin
      send(8'(samp[i]));
      check("t1_busy", 32'(bus.busy), 1);
      wait_result("t1_out");
      // Counted from the cycle the sample is presented to the first cycle with a result.
      check("t1_latency", 32'(valid_cyc - accept_cyc + 1), N + 1);
      if (i > 0) check("t1_spacing", 32'(accept_cyc - prev_acc), N + 2);
      prev_acc = accept_cyc;
    end
    check("t1_last", 32'(bus.out_data), 100);

    // Programmed coefficients from a cleared delay line.
    do_reset();
    for (int i = 0; i < N; i++) write_coef(i, i + 1, 1'b1);
    send(8'd5);
    wait_result("t2_first");
    send(8'd7);
    wait_result("t2_second");
    check("t2_value", 32'(bus.out_data), 17);

    // Backpressure: result held, samples refused, then exactly one transfer.
    @(negedge clk);
    wait_idle();
    bus.out_ready = 1'b0;
    send(8'd11);
    wait_result("t3_out");
    held  = bus.out_data;
    xfer0 = n_xfer;
    acc0  = n_acc;
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = i[0];
      bus.in_data  = 8'($urandom_range(0, 255));
      @(negedge clk);
      check("t3_valid_hold", 32'(bus.out_valid), 1);
      check("t3_data_hold", 32'(bus.out_data), 32'(held));
      check("t3_in_ready", 32'(bus.in_ready), 0);
    end
    bus.in_valid  = 1'b0;
    check("t3_no_accept", 32'(n_acc - acc0), 0);
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("t3_one_xfer", 32'(n_xfer - xfer0), 1);
    check("t3_ready_back", 32'(bus.in_ready), 1);
    check("t3_valid_drop", 32'(bus.out_valid), 0);

    // A coefficient write while busy is dropped; the same write while idle takes effect.
    send(8'd2);
    check("t4_busy", 32'(bus.busy), 1);
    write_coef(0, 9, 1'b0);
    wait_result("t4_dropped");
    @(negedge clk);
    wait_idle();
    write_coef(0, 9, 1'b1);
    send(8'd4);
    wait_result("t4_taken");

    // Largest possible sum: 4 * 255 * 255.
    do_reset();
    for (int i = 0; i < N; i++) write_coef(i, 255, 1'b1);
    for (int i = 0; i < 4; i++) begin
      send(8'd255);
      wait_result("t5_out");
    end
`ifdef FIR_SAT_EN
    check("t5_edge", 32'(bus.out_data), 32'hFFFF);
`else
    check("t5_edge", 32'(bus.out_data), 32'hF804);
`endif

    // Reset in the second MAC cycle discards the partial result.
    @(negedge clk);
    wait_idle();
    send(8'd50);
    @(negedge clk);
    v0 = n_valid;
    reset = 1'b0;
    model_reset();
    @(negedge clk);
    check("t6_in_ready", 32'(bus.in_ready), 1);
    check("t6_out_data", 32'(bus.out_data), 0);
    check("t6_busy", 32'(bus.busy), 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (8) @(negedge clk);
    check("t6_no_valid", 32'(n_valid - v0), 0);
    send(8'd3);
    wait_result("t6_after");
    check("t6_value", 32'(bus.out_data), 3);

    // Random samples, idle coefficient loads and consumer stalls.
    for (int it = 0; it < 24; it++) begin
      int bp;
      @(negedge clk);
      wait_idle();
      if ($urandom_range(0, 1) == 1)
        write_coef(int'($urandom_range(0, N - 1)), int'($urandom_range(0, 255)), 1'b1);
      bp = int'($urandom_range(0, 3));
      bus.out_ready = (bp == 0);
      send(8'($urandom_range(0, 255)));
      wait_result("rnd_out");
      repeat (bp) @(negedge clk);
      check("rnd_hold", 32'(bus.out_data), model_out());
      bus.out_ready = 1'b1;
    end

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
